// File: rtl/game_round_timer.sv
// Round countdown timer: arms on startGame, counts GAME_SECONDS of synchronized 1Hz ticks, pulses timer_expired.
// Optional low-time blink output `warn` is built only when GAME_TIMER_WARN_EN is defined.
module game_round_timer #(
  parameter int GAME_SECONDS = 30,
  parameter int WARN_SECONDS = 5
) (
  input  logic       clkIn,
  input  logic       reset,
  input  logic       incrementClk,
  input  logic       startGame,
  input  logic       game_active,
  output logic       timer_expired,
  output logic       running,
  output logic [5:0] seconds_left,
  output logic [3:0] secs_tens,
  output logic [3:0] secs_ones,
`ifdef GAME_TIMER_WARN_EN
  output logic       warn,
`endif
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] LOAD_SECS = 6'(GAME_SECONDS);
  localparam logic [3:0] LOAD_TENS = 4'(GAME_SECONDS / 10);
  localparam logic [3:0] LOAD_ONES = 4'(GAME_SECONDS % 10);

  state_t state;
  state_t state_next;
  logic   sync_1;
  logic   sync_2;
  logic   sync_2_d;
  logic   tick;
  logic   load;
  logic   dec;
  logic   expire_next;

  // incrementClk is data here: two-flop synchronizer, then rising-edge detect
  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      sync_1   <= 1'b0;
      sync_2   <= 1'b0;
      sync_2_d <= 1'b0;
    end else begin
      sync_1   <= incrementClk;
      sync_2   <= sync_1;
      sync_2_d <= sync_2;
    end
  end

  assign tick = sync_2 & ~sync_2_d;

  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (startGame) state_next = RUN;
      RUN: begin
        if (!game_active) begin
          state_next = IDLE;
        end else if (tick && (seconds_left == 6'd1)) begin
          state_next = DONE;
        end
      end
      DONE: if (startGame) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Abort outranks a tick landing in the same cycle
  always_comb begin
    load        = 1'b0;
    dec         = 1'b0;
    expire_next = 1'b0;
    case (state)
      IDLE: load = startGame;
      RUN: begin
        if (!game_active) begin
          load = 1'b1;
        end else if (tick) begin
          dec         = 1'b1;
          expire_next = (seconds_left == 6'd1);
        end
      end
      DONE: load = startGame;
      default: load = 1'b1;
    endcase
  end

  // Binary and BCD counters move together so the digits never disagree
  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      seconds_left  <= LOAD_SECS;
      secs_tens     <= LOAD_TENS;
      secs_ones     <= LOAD_ONES;
      timer_expired <= 1'b0;
    end else begin
      timer_expired <= expire_next;
      if (load) begin
        seconds_left <= LOAD_SECS;
        secs_tens    <= LOAD_TENS;
        secs_ones    <= LOAD_ONES;
      end else if (dec) begin
        seconds_left <= seconds_left - 6'd1;
        if (secs_ones == 4'd0) begin
          secs_ones <= 4'd9;
          secs_tens <= secs_tens - 4'd1;
        end else begin
          secs_ones <= secs_ones - 4'd1;
        end
      end
    end
  end

`ifdef GAME_TIMER_WARN_EN
  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      warn <= 1'b0;
    end else begin
      warn <= (state == RUN) && (seconds_left <= 6'(WARN_SECONDS)) && sync_2;
    end
  end
`endif

  assign running   = (state == RUN);
  assign fsm_state = state;

endmodule

// File: tb/tb_game_round_timer.sv
// Bench for game_round_timer: directed vector table, hand sequences for expiry/async reset, random run vs model.
module tb_game_round_timer;

  localparam int GS = 30;
  localparam int WS = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ic_r;
  logic       start_r;
  logic       active_r;
  logic       timer_expired;
  logic       running;
  logic [5:0] seconds_left;
  logic [3:0] secs_tens;
  logic [3:0] secs_ones;
  logic [1:0] fsm_state;
`ifdef GAME_TIMER_WARN_EN
  logic       warn;
`endif

  int checks = 0;
  int errors = 0;

  game_round_timer #(.GAME_SECONDS(GS), .WARN_SECONDS(WS)) dut (
    .clkIn        (clk),
    .reset        (rst_n),
    .incrementClk (ic_r),
    .startGame    (start_r),
    .game_active  (active_r),
    .timer_expired(timer_expired),
    .running      (running),
    .seconds_left (seconds_left),
    .secs_tens    (secs_tens),
    .secs_ones    (secs_ones),
`ifdef GAME_TIMER_WARN_EN
    .warn         (warn),
`endif
    .fsm_state    (fsm_state)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 running, 2 finished; ticks are queued by due edge number
  int m_mode;
  int m_secs;
  bit m_exp;
  bit m_warn;
  int edge_n;
  int due_q[$];
  bit ic_prev;
  bit ic_h1;
  bit ic_h2;

  task automatic model_reset();
    m_mode = 0; m_secs = GS; m_exp = 0; m_warn = 0;
    edge_n = 0; due_q.delete(); ic_prev = 0; ic_h1 = 0; ic_h2 = 0;
  endtask

  task automatic model_edge();
    bit tick;
    bit nexp;
    edge_n++;
    tick = 0;
    while (due_q.size() > 0 && due_q[0] == edge_n) begin
      void'(due_q.pop_front());
      tick = 1;
    end
    if (ic_r && !ic_prev) due_q.push_back(edge_n + 2);
    ic_prev = ic_r;
    m_warn = (m_mode == 1) && (m_secs <= WS) && ic_h2;
    ic_h2 = ic_h1;
    ic_h1 = ic_r;
    nexp = 0;
    case (m_mode)
      0: if (start_r) begin m_mode = 1; m_secs = GS; end
      1: begin
        if (!active_r) begin
          m_mode = 0; m_secs = GS;
        end else if (tick) begin
          if (m_secs > 1) m_secs--;
          else begin m_secs = 0; nexp = 1; m_mode = 2; end
        end
      end
      default: if (start_r) begin m_mode = 1; m_secs = GS; end
    endcase
    m_exp = nexp;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_secs"}, int'(seconds_left), GS);
    chk({tag, "_tens"}, int'(secs_tens), GS / 10);
    chk({tag, "_ones"}, int'(secs_ones), GS % 10);
    chk({tag, "_running"}, int'(running), 0);
    chk({tag, "_expired"}, int'(timer_expired), 0);
`ifdef GAME_TIMER_WARN_EN
    chk({tag, "_warn"}, int'(warn), 0);
`endif
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_secs"}, int'(seconds_left), m_secs);
    chk({tag, "_tens"}, int'(secs_tens), m_secs / 10);
    chk({tag, "_ones"}, int'(secs_ones), m_secs % 10);
    chk({tag, "_running"}, int'(running), int'(m_mode == 1));
    chk({tag, "_expired"}, int'(timer_expired), int'(m_exp));
`ifdef GAME_TIMER_WARN_EN
    chk({tag, "_warn"}, int'(warn), int'(m_warn));
`endif
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; ic_r = 1'b0; start_r = 1'b0; active_r = 1'b1;
    model_reset();
    #20;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse();
    ic_r = 1'b1; cyc(); cyc();
    ic_r = 1'b0; cyc(); cyc();
  endtask

  typedef struct {
    logic       start;
    logic       active;
    logic       ic;
    logic       exp_running;
    logic [5:0] exp_secs;
    logic [3:0] exp_tens;
    logic [3:0] exp_ones;
    logic       exp_expired;
  } vec_t;

  vec_t vecs[13];

  initial begin
    rst_n = 1'b0; ic_r = 1'b0; start_r = 1'b0; active_r = 1'b1;
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 6'd30, 4'd3, 4'd0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd30, 4'd3, 4'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd30, 4'd3, 4'd0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd29, 4'd2, 4'd9, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 6'd29, 4'd2, 4'd9, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd29, 4'd2, 4'd9, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd29, 4'd2, 4'd9, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd28, 4'd2, 4'd8, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 6'd28, 4'd2, 4'd8, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd28, 4'd2, 4'd8, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd28, 4'd2, 4'd8, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'd30, 4'd3, 4'd0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'd30, 4'd3, 4'd0, 1'b0};

    apply_reset();

    // Directed table: start, tick latency, restart ignored, abort with coincident tick
    for (int i = 0; i < 13; i++) begin
      start_r = vecs[i].start; active_r = vecs[i].active; ic_r = vecs[i].ic;
      cyc();
      chk($sformatf("vec%0d_running", i), int'(running), int'(vecs[i].exp_running));
      chk($sformatf("vec%0d_secs", i), int'(seconds_left), int'(vecs[i].exp_secs));
      chk($sformatf("vec%0d_tens", i), int'(secs_tens), int'(vecs[i].exp_tens));
      chk($sformatf("vec%0d_ones", i), int'(secs_ones), int'(vecs[i].exp_ones));
      chk($sformatf("vec%0d_expired", i), int'(timer_expired), int'(vecs[i].exp_expired));
    end

    // Full round to expiry, start coinciding with the expiry tick, then restart from DONE
    start_r = 1'b1; ic_r = 1'b0; active_r = 1'b1;
    cyc();
    start_r = 1'b0;
    chk("round_start_running", int'(running), 1);
    for (int i = 0; i < GS - 1; i++) pulse();
    chk("round_last_sec", int'(seconds_left), 1);
    chk("round_last_ones", int'(secs_ones), 1);
    chk("round_last_running", int'(running), 1);
    ic_r = 1'b1; cyc(); cyc();
    chk("pre_expiry_secs", int'(seconds_left), 1);
    chk("pre_expiry_expired", int'(timer_expired), 0);
    start_r = 1'b1;
    cyc();
    start_r = 1'b0;
    chk("expiry_secs", int'(seconds_left), 0);
    chk("expiry_tens", int'(secs_tens), 0);
    chk("expiry_ones", int'(secs_ones), 0);
    chk("expiry_pulse", int'(timer_expired), 1);
    chk("expiry_running", int'(running), 0);
    cyc();
    chk("post_expiry_pulse", int'(timer_expired), 0);
    chk("post_expiry_running", int'(running), 0);
    chk("post_expiry_secs", int'(seconds_left), 0);
    ic_r = 1'b0;
    repeat (3) cyc();
    chk("done_hold_secs", int'(seconds_left), 0);
    start_r = 1'b1;
    cyc();
    start_r = 1'b0;
    chk("done_restart_running", int'(running), 1);
    chk("done_restart_secs", int'(seconds_left), GS);
    pulse(); pulse();
    chk("restart_count_secs", int'(seconds_left), GS - 2);

    // Asynchronous reset between clock edges
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    model_reset();
    ic_r = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Random run against the model, incrementClk as a 20-cycle square wave
    for (int c = 0; c < 6000; c++) begin
      ic_r     = ((c % 20) >= 10);
      start_r  = ($urandom_range(0, 29) == 0);
      active_r = ($urandom_range(0, 1499) != 0);
      cyc();
      check_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
